// File: rtl/imm_extend_seq.sv
// Sequential immediate extender: decodes Instr/ImmSrc into a WIDTH-bit immediate,
// performing the mode-011 rotate over several cycles, with valid/ready handshakes.
module imm_extend_seq #(
    parameter int WIDTH    = 32,
    parameter int ROT_STEP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [23:0]      Instr,
    input  logic [2:0]       ImmSrc,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] ExtImm,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

    state_t           state, state_d;
    logic [4:0]       remaining, step;
    logic [WIDTH-1:0] imm_final;
    logic             illegal, rot_req, accept;
    logic [31:0]      work_rot;

    // Mode 011 loads the unrotated byte; the rotation happens in ROTATE.
    always_comb begin
        imm_final = '0;
        illegal   = 1'b0;
        case (ImmSrc)
            3'b000: imm_final = {{(WIDTH-8){1'b0}}, Instr[7:0]};
            3'b001: imm_final = {{(WIDTH-12){1'b0}}, Instr[11:0]};
            3'b010: imm_final = {{(WIDTH-26){Instr[23]}}, Instr[23:0], 2'b00};
            3'b011: imm_final = {{(WIDTH-8){1'b0}}, Instr[7:0]};
            3'b100: imm_final = {{(WIDTH-12){Instr[11]}}, Instr[11:0]};
            3'b101: imm_final = {{(WIDTH-8){1'b0}}, Instr[11:8], Instr[3:0]};
            default: illegal  = 1'b1;
        endcase
    end

    assign rot_req = (ImmSrc == 3'b011) && (Instr[11:8] != 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = rot_req ? ROTATE : DONE;
            end
            ROTATE: begin
                if (remaining == step) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) state_d = rot_req ? ROTATE : DONE;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign busy   = (state != IDLE);

    // remaining is always even, so the last step may be shorter than ROT_STEP.
    assign step     = (remaining < 5'(ROT_STEP)) ? remaining : 5'(ROT_STEP);
    assign work_rot = (ExtImm[31:0] >> step) | (ExtImm[31:0] << (6'd32 - {1'b0, step}));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ExtImm    <= '0;
            err       <= 1'b0;
            remaining <= '0;
        end else if (accept) begin
            ExtImm    <= imm_final;
            err       <= illegal;
            remaining <= rot_req ? {Instr[11:8], 1'b0} : 5'd0;
        end else if (state == ROTATE) begin
            ExtImm[31:0] <= work_rot;
            remaining    <= remaining - step;
        end
    end

endmodule

// File: tb/tb_imm_extend_seq.sv
// Randomized bench for imm_extend_seq: two instances (32-bit/step 2 and 40-bit/step 8)
// share stimulus and are checked against an arithmetic reference model.
module tb_imm_extend_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] Instr;
    logic [2:0]  ImmSrc;
    logic        in_valid, out_ready;

    logic        a_in_ready, a_err, a_ov, a_busy;
    logic [31:0] a_ext;
    logic        b_in_ready, b_err, b_ov, b_busy;
    logic [39:0] b_ext;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_extend_seq #(.WIDTH(32), .ROT_STEP(2)) dut_a (
        .clk(clk), .reset(reset), .Instr(Instr), .ImmSrc(ImmSrc),
        .in_valid(in_valid), .in_ready(a_in_ready), .ExtImm(a_ext), .err(a_err),
        .out_valid(a_ov), .out_ready(out_ready), .busy(a_busy));

    imm_extend_seq #(.WIDTH(40), .ROT_STEP(8)) dut_b (
        .clk(clk), .reset(reset), .Instr(Instr), .ImmSrc(ImmSrc),
        .in_valid(in_valid), .in_ready(b_in_ready), .ExtImm(b_ext), .err(b_err),
        .out_valid(b_ov), .out_ready(out_ready), .busy(b_busy));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [23:0] ins, input logic [2:0] src, input int w);
        longint v;
        longint base;
        int     r;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case (src)
            3'd0: v = longint'(ins[7:0]);
            3'd1: v = longint'(ins[11:0]);
            3'd2: begin
                v = longint'(ins) * 4;
                if (ins[23]) v = v - (longint'(1) << 26);
            end
            3'd3: begin
                base = longint'(ins[7:0]);
                r    = 2 * int'(ins[11:8]);
                v    = (((base << 32) | base) >> r) & longint'(32'hFFFF_FFFF);
            end
            3'd4: begin
                v = longint'(ins[11:0]);
                if (ins[11]) v = v - 4096;
            end
            3'd5: v = longint'(ins[11:8]) * 16 + longint'(ins[3:0]);
            default: v = 0;
        endcase
        return 64'(v) & mask;
    endfunction

    function automatic int lat(input logic [23:0] ins, input logic [2:0] src, input int stp);
        if (src == 3'd3) return 1 + (2 * int'(ins[11:8]) + stp - 1) / stp;
        return 1;
    endfunction

    // Presents a request and returns #1 after the accepting edge.
    task automatic issue(input logic [23:0] ins, input logic [2:0] src, input logic rdy);
        Instr     = ins;
        ImmSrc    = src;
        in_valid  = 1'b1;
        out_ready = rdy;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    // Called #1 after the accept edge; garbage on Instr with in_valid high must be ignored.
    task automatic collect(input logic [23:0] ins, input logic [2:0] src, input string tag);
        int la = 0, lb = 0;
        in_valid = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            Instr  = 24'($urandom);
            ImmSrc = 3'($urandom);
            if (la == 0 && a_ov) la = c;
            if (lb == 0 && b_ov) lb = c;
            if (c == 1 && src == 3'd3 && ins[11:8] != 4'd0)
                chk({tag, " rot_in_ready"}, {63'd0, a_in_ready}, 64'd0);
            if (la != 0 && lb != 0) break;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk({tag, " lat_a"}, 64'(la), 64'(lat(ins, src, 2)));
        chk({tag, " lat_b"}, 64'(lb), 64'(lat(ins, src, 8)));
        chk({tag, " ext_a"}, 64'(a_ext), model(ins, src, 32));
        chk({tag, " ext_b"}, 64'(b_ext), model(ins, src, 40));
        chk({tag, " err_a"}, {63'd0, a_err}, {63'd0, src >= 3'd6});
        chk({tag, " err_b"}, {63'd0, b_err}, {63'd0, src >= 3'd6});
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " idle_ov"}, {62'd0, a_ov, b_ov}, 64'd0);
        chk({tag, " idle_busy"}, {62'd0, a_busy, b_busy}, 64'd0);
    endtask

    logic [23:0] dir_ins [8] = '{24'h0000AB, 24'hFFFFFE, 24'h000FFF, 24'h5A5A5A,
                                 24'h000800, 24'h000A05, 24'h000ABC, 24'h0000C3};
    logic [2:0]  dir_src [8] = '{3'd0, 3'd2, 3'd3, 3'd7, 3'd4, 3'd5, 3'd1, 3'd3};

    initial begin
        logic [31:0] held_a;
        logic [39:0] held_b;
        logic [23:0] ins, nins;
        logic [2:0]  src, nsrc;

        reset = 1'b1; Instr = '0; ImmSrc = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ov", {62'd0, a_ov, b_ov}, 64'd0);
        chk("reset_ext", 64'(a_ext) | 64'(b_ext), 64'd0);
        chk("reset_err", {62'd0, a_err, b_err}, 64'd0);
        chk("reset_busy", {62'd0, a_busy, b_busy}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("post_reset_in_ready", {62'd0, a_in_ready, b_in_ready}, 64'd3);

        for (int i = 0; i < 8; i++) begin
            issue(dir_ins[i], dir_src[i], 1'b0);
            collect(dir_ins[i], dir_src[i], $sformatf("dir%0d", i));
            retire($sformatf("dir%0d", i));
        end

        // Stall in DONE, then back-to-back accept on release.
        issue(24'h123456, 3'd2, 1'b0);
        collect(24'h123456, 3'd2, "hold");
        held_a = a_ext; held_b = b_ext;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            Instr = 24'($urandom);
            @(posedge clk); #1;
            chk("hold_ext_a", 64'(a_ext), 64'(held_a));
            chk("hold_ext_b", 64'(b_ext), 64'(held_b));
            chk("hold_in_ready", {62'd0, a_in_ready, b_in_ready}, 64'd0);
            chk("hold_ov", {62'd0, a_ov, b_ov}, 64'd3);
        end
        issue(24'h0000F7, 3'd0, 1'b1);
        chk("b2b_ov", {62'd0, a_ov, b_ov}, 64'd3);
        collect(24'h0000F7, 3'd0, "b2b");
        retire("b2b");

        // Random traffic, sometimes issued back-to-back from DONE.
        src = 3'($urandom); ins = 24'($urandom);
        issue(ins, src, 1'b0);
        for (int i = 0; i < 60; i++) begin
            collect(ins, src, $sformatf("rnd%0d", i));
            nsrc = 3'($urandom); nins = 24'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                issue(nins, nsrc, 1'b1);
            end else begin
                retire($sformatf("rnd%0d", i));
                issue(nins, nsrc, 1'b0);
            end
            ins = nins; src = nsrc;
        end
        collect(ins, src, "rnd_last");
        retire("rnd_last");

        // Asynchronous reset in the middle of a rotation.
        issue(24'h000F01, 3'd3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrot_busy", {62'd0, a_busy, b_busy}, 64'd3);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk("arst_ov", {62'd0, a_ov, b_ov}, 64'd0);
        chk("arst_busy", {62'd0, a_busy, b_busy}, 64'd0);
        chk("arst_ext", 64'(a_ext) | 64'(b_ext), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(24'h000042, 3'd0, 1'b0);
        collect(24'h000042, 3'd0, "after_rst");
        retire("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_extend_seq.md
IMM_EXTEND_SEQ -- requirements
Module: imm_extend_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: ExtImm width; legal values >= 32.
REQ-002 The block SHALL have parameter ROT_STEP, default 2: bits rotated per ROTATE cycle; legal values 2, 4, 8.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port Instr, input, 24: instruction immediate field.
REQ-006 The block SHALL have port ImmSrc, input, 3: extension mode select.
REQ-007 The block SHALL have port in_valid, input, 1: Instr/ImmSrc valid.
REQ-008 The block SHALL have port in_ready, output, 1: block accepts a request this cycle.
REQ-009 The block SHALL have port ExtImm, output, WIDTH: extended immediate.
REQ-010 The block SHALL have port err, output, 1: illegal ImmSrc flag, qualified by out_valid.
REQ-011 The block SHALL have port out_valid, output, 1: ExtImm/err valid.
REQ-012 The block SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 The block SHALL have port busy, output, 1: high when state != IDLE.

Function
REQ-014 A request SHALL be accepted on any cycle where in_valid && in_ready; Instr and ImmSrc are captured at that edge.
REQ-015 Modes SHALL be: 000 zero-extend Instr[7:0]; 001 zero-extend Instr[11:0]; 010 sign-extend {Instr[23:0],2'b00}; 011 rotated immediate, Instr[7:0] zero-extended to 32 bits then rotated right by 2*Instr[11:8]; 100 sign-extend Instr[11:0]; 101 zero-extend {Instr[11:8],Instr[3:0]}.
REQ-016 ImmSrc 110 or 111 SHALL produce ExtImm = 0 and err = 1; all legal modes produce err = 0.
REQ-017 Width rule: zero-extended modes SHALL fill ExtImm[WIDTH-1:msb+1] with 0; sign-extended modes SHALL replicate the source MSB up to bit WIDTH-1; mode 011 rotates within bits [31:0] only, with bits above 31 = 0.
REQ-018 The FSM SHALL have states IDLE, ROTATE, DONE; reset state IDLE.
REQ-019 IDLE: in_ready = 1; on accept with mode 011 and Instr[11:8] != 0, go to ROTATE; on any other accept, go to DONE with final ExtImm loaded.
REQ-020 ROTATE: in_ready = 0; each cycle rotate the working value right by min(ROT_STEP, remaining) and decrement remaining; when remaining reaches 0, go to DONE.
REQ-021 Rotation remaining count SHALL start at 2*Instr[11:8], so ROTATE occupies ceil(2*Instr[11:8]/ROT_STEP) cycles.
REQ-022 Latency: result SHALL appear with out_valid = 1 one cycle after accept for non-rotating requests, and 1 + ceil(2*Instr[11:8]/ROT_STEP) cycles after accept for mode 011.
REQ-023 DONE: out_valid = 1; ExtImm and err SHALL remain stable while out_ready = 0.
REQ-024 DONE with out_ready = 1 SHALL retire the result; in_ready = out_ready in DONE, so a new request accepted in the same cycle goes directly to DONE or ROTATE with no bubble.
REQ-025 DONE with out_ready = 1 and no new accept SHALL return to IDLE with out_valid = 0.
REQ-026 in_valid SHALL be ignored in ROTATE and in DONE while out_ready = 0.
REQ-027 out_valid SHALL never be 1 outside DONE; busy = (state != IDLE).

Reset
REQ-028 reset = 1 SHALL, asynchronously and regardless of state (including mid-ROTATE), force IDLE, out_valid = 0, ExtImm = 0, err = 0, remaining = 0; in_ready = 1 after reset deasserts.
REQ-029 The first edge after reset deasserts SHALL be able to accept a request.

Verification
REQ-030 Scenario: ImmSrc = 000, Instr = 24'h0000AB accepted at cycle N -> out_valid at N+1, ExtImm = 32'h000000AB, err = 0.
REQ-031 Scenario: ImmSrc = 010, Instr = 24'hFFFFFE -> ExtImm = 32'hFFFFFFF8; with WIDTH = 40 -> 40'hFFFFFFFFF8.
REQ-032 Scenario: ImmSrc = 011, Instr = 24'h000FFF, ROT_STEP = 2 -> 15 ROTATE cycles, out_valid at N+16, ExtImm = 32'h000003FC; ROT_STEP = 8 -> out_valid at N+5, same value.
REQ-033 Scenario: result in DONE, out_ready held 0 for 5 cycles -> ExtImm and err stable, in_ready = 0; out_ready = 1 with in_valid = 1 -> back-to-back accept, next out_valid exactly 1 cycle later.
REQ-034 Scenario: ImmSrc = 111, any Instr -> ExtImm = 0, err = 1, out_valid after 1 cycle.
REQ-035 Scenario: reset asserted during ROTATE of Instr = 24'h000F01 -> immediately IDLE, out_valid = 0, busy = 0; after release, a new mode-000 request completes normally.
